xfm_rec_sched: RTL and testbench

- Time-multiplexes one shared single-component dequant/inverse-transform engine (one xfm_rec_c-class instance) across the three colour components of a 4x4 transform block, instead of instantiating three engines.
- Accepts a full 3-component coefficient block, issues non-zero components to the engine in order, collects returned residuals by component index, and presents the assembled block downstream.
- Sits between the entropy-decode/coefficient stage and the reconstruction adder.

---
 rtl/xfm_rec_sched.sv | 201 ++++++++++++++++++++
 tb/tb_xfm_rec_sched.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xfm_rec_sched.sv
// Time-multiplexes one shared dequant/inverse-transform engine across the three colour
// components of a 4x4 block, collecting residuals by component and presenting the full block.
module xfm_rec_sched #(
  parameter int unsigned COEFF_SIZE = 9,
  parameter int unsigned RES_W      = 12,
  parameter int unsigned MAX_OUTST  = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [7:0]                 in_qp_i,
  input  logic [3*16*COEFF_SIZE-1:0] in_coeff_i,
  output logic                       eng_valid_o,
  input  logic                       eng_ready_i,
  output logic [1:0]                 eng_comp_o,
  output logic [7:0]                 eng_qp_o,
  output logic [16*COEFF_SIZE-1:0]   eng_coeff_o,
  input  logic                       res_valid_i,
  input  logic [1:0]                 res_comp_i,
  input  logic [16*RES_W-1:0]        res_data_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [3*16*RES_W-1:0]      out_res_o,
  output logic [2:0]                 out_zmask_o,
  output logic                       busy_o,
  output logic                       err_o
);

  localparam int unsigned CompW    = 16 * COEFF_SIZE;
  localparam int unsigned ResW     = 16 * RES_W;
  localparam logic [1:0]  MaxOutst = 2'(MAX_OUTST);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]                 state_q, state_d;
  logic [7:0]                 qp_q, qp_d;
  logic [3*CompW-1:0]         coeff_q, coeff_d;
  logic [2:0]                 zmask_q, zmask_d;
  logic [2:0]                 issued_q, issued_d;
  logic [2:0]                 returned_q, returned_d;
  logic [1:0]                 outst_q, outst_d;
  logic [1:0]                 comp_q, comp_d;
  logic [3*ResW-1:0]          res_q, res_d;
  logic                       err_q, err_d;

  logic [2:0] in_zmask;
  logic [2:0] above_mask;
  logic [2:0] next_cand;
  logic [2:0] ret_sel;
  logic [2:0] issue_sel;
  logic       issue;
  logic       ret_ok;

  function automatic logic [1:0] lowest(input logic [2:0] cand);
    logic [1:0] idx;
    if (cand[0])      idx = 2'd0;
    else if (cand[1]) idx = 2'd1;
    else              idx = 2'd2;
    return idx;
  endfunction

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      in_zmask[k] = (in_coeff_i[k*CompW +: CompW] == '0);
    end
  end

  always_comb begin
    above_mask = 3'b000;
    issue_sel  = 3'b000;
    case (comp_q)
      2'd0: begin above_mask = 3'b110; issue_sel = 3'b001; end
      2'd1: begin above_mask = 3'b100; issue_sel = 3'b010; end
      2'd2: begin above_mask = 3'b000; issue_sel = 3'b100; end
      default: ;
    endcase
  end

  // Component 3 decodes to nothing, so it can never match an issued slot.
  always_comb begin
    ret_sel = 3'b000;
    case (res_comp_i)
      2'd0:    ret_sel = 3'b001;
      2'd1:    ret_sel = 3'b010;
      2'd2:    ret_sel = 3'b100;
      default: ret_sel = 3'b000;
    endcase
  end

  assign next_cand   = ~zmask_q & above_mask;
  assign eng_valid_o = (state_q == StIssue) && (outst_q != MaxOutst);
  assign issue       = eng_valid_o && eng_ready_i;
  assign ret_ok      = res_valid_i && ((state_q == StIssue) || (state_q == StWait)) &&
                       ((ret_sel & issued_q & ~returned_q) != 3'b000);

  always_comb begin
    state_d    = state_q;
    qp_d       = qp_q;
    coeff_d    = coeff_q;
    zmask_d    = zmask_q;
    issued_d   = issued_q;
    returned_d = returned_q;
    outst_d    = outst_q;
    comp_d     = comp_q;
    res_d      = res_q;
    err_d      = err_q | (res_valid_i & ~ret_ok);

    if (ret_ok) begin
      returned_d = returned_q | ret_sel;
      for (int k = 0; k < 3; k++) begin
        if (ret_sel[k]) res_d[k*ResW +: ResW] = res_data_i;
      end
    end

    case ({issue, ret_ok})
      2'b10:   outst_d = outst_q + 2'd1;
      2'b01:   outst_d = outst_q - 2'd1;
      default: outst_d = outst_q;
    endcase

    case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          qp_d       = in_qp_i;
          coeff_d    = in_coeff_i;
          zmask_d    = in_zmask;
          res_d      = '0;
          issued_d   = 3'b000;
          returned_d = 3'b000;
          outst_d    = 2'd0;
          comp_d     = lowest(~in_zmask);
          state_d    = (in_zmask == 3'b111) ? StDone : StIssue;
        end
      end
      StIssue: begin
        if (issue) begin
          issued_d = issued_q | issue_sel;
          if (next_cand != 3'b000) comp_d  = lowest(next_cand);
          else                     state_d = StWait;
        end
      end
      StWait: begin
        // Uses the post-return mask so the block completes the cycle after the last return.
        if (returned_d == issued_q) state_d = StDone;
      end
      StDone: begin
        if (out_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      qp_q       <= '0;
      coeff_q    <= '0;
      zmask_q    <= '0;
      issued_q   <= '0;
      returned_q <= '0;
      outst_q    <= '0;
      comp_q     <= '0;
      res_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      qp_q       <= qp_d;
      coeff_q    <= coeff_d;
      zmask_q    <= zmask_d;
      issued_q   <= issued_d;
      returned_q <= returned_d;
      outst_q    <= outst_d;
      comp_q     <= comp_d;
      res_q      <= res_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    eng_coeff_o = coeff_q[0 +: CompW];
    case (comp_q)
      2'd1:    eng_coeff_o = coeff_q[CompW +: CompW];
      2'd2:    eng_coeff_o = coeff_q[2*CompW +: CompW];
      default: eng_coeff_o = coeff_q[0 +: CompW];
    endcase
  end

  assign in_ready_o  = (state_q == StIdle);
  assign eng_comp_o  = comp_q;
  assign eng_qp_o    = qp_q;
  assign out_valid_o = (state_q == StDone);
  assign out_res_o   = (state_q == StDone) ? res_q : '0;
  assign out_zmask_o = (state_q == StDone) ? zmask_q : 3'b000;
  assign busy_o      = (state_q != StIdle);
  assign err_o       = err_q;

endmodule

// File: tb/tb_xfm_rec_sched.sv
// Bench for xfm_rec_sched: randomized blocks against a cycle-level engine and block model.
module tb_xfm_rec_sched;

  localparam int CS  = 9;
  localparam int RW  = 12;
  localparam int CW  = 3 * 16 * CS;
  localparam int EW  = 16 * CS;
  localparam int RCW = 16 * RW;
  localparam int OW  = 3 * RCW;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic          in_valid, in_ready, eng_valid, eng_ready, res_valid, out_valid, out_ready;
  logic          busy, err;
  logic [7:0]    in_qp, eng_qp;
  logic [CW-1:0] in_coeff;
  logic [1:0]    eng_comp, res_comp;
  logic [EW-1:0] eng_coeff;
  logic [RCW-1:0] res_data;
  logic [OW-1:0] out_res;
  logic [2:0]    out_zmask;

  logic          in_valid_b, in_ready_b, eng_valid_b, eng_ready_b, res_valid_b;
  logic          out_valid_b, out_ready_b, busy_b, err_b;
  logic [7:0]    in_qp_b, eng_qp_b;
  logic [CW-1:0] in_coeff_b;
  logic [1:0]    eng_comp_b, res_comp_b;
  logic [EW-1:0] eng_coeff_b;
  logic [RCW-1:0] res_data_b;
  logic [OW-1:0] out_res_b;
  logic [2:0]    out_zmask_b;

  int   vec = 0;
  int   errs = 0;
  logic exp_err = 1'b0;

  xfm_rec_sched #(.COEFF_SIZE(CS), .RES_W(RW), .MAX_OUTST(3)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready), .in_qp_i(in_qp),
    .in_coeff_i(in_coeff), .eng_valid_o(eng_valid), .eng_ready_i(eng_ready),
    .eng_comp_o(eng_comp), .eng_qp_o(eng_qp), .eng_coeff_o(eng_coeff),
    .res_valid_i(res_valid), .res_comp_i(res_comp), .res_data_i(res_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_res_o(out_res),
    .out_zmask_o(out_zmask), .busy_o(busy), .err_o(err)
  );

  xfm_rec_sched #(.COEFF_SIZE(CS), .RES_W(RW), .MAX_OUTST(1)) dut_b (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid_b), .in_ready_o(in_ready_b),
    .in_qp_i(in_qp_b), .in_coeff_i(in_coeff_b), .eng_valid_o(eng_valid_b),
    .eng_ready_i(eng_ready_b), .eng_comp_o(eng_comp_b), .eng_qp_o(eng_qp_b),
    .eng_coeff_o(eng_coeff_b), .res_valid_i(res_valid_b), .res_comp_i(res_comp_b),
    .res_data_i(res_data_b), .out_valid_o(out_valid_b), .out_ready_i(out_ready_b),
    .out_res_o(out_res_b), .out_zmask_o(out_zmask_b), .busy_o(busy_b), .err_o(err_b)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CW-1:0] rand_coeff(input logic [2:0] zm);
    logic [CW-1:0] c = '0;
    int j0;
    for (int k = 0; k < 3; k++) begin
      if (!zm[k]) begin
        for (int j = 0; j < 16; j++) begin
          if ($urandom_range(0, 2) != 0) c[(k*16+j)*CS +: CS] = CS'($urandom);
        end
        j0 = $urandom_range(0, 15);
        c[(k*16+j0)*CS +: CS] = CS'($urandom_range(1, 511));
      end
    end
    return c;
  endfunction

  function automatic logic [RCW-1:0] rand_res();
    logic [RCW-1:0] r;
    for (int i = 0; i < RCW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [2:0] zmask_of(input logic [CW-1:0] c);
    logic [2:0] z = 3'b111;
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 16; j++)
        if (c[(k*16+j)*CS +: CS] != '0) z[k] = 1'b0;
    return z;
  endfunction

  function automatic logic [EW-1:0] slot_coeff(input logic [CW-1:0] c, input int k);
    return c[k*EW +: EW];
  endfunction

  task automatic do_reset;
    rst = 1'b1;
    in_valid = 0; in_qp = 0; in_coeff = '0; eng_ready = 0; res_valid = 0; res_comp = 0;
    res_data = '0; out_ready = 0;
    in_valid_b = 0; in_qp_b = 0; in_coeff_b = '0; eng_ready_b = 0; res_valid_b = 0;
    res_comp_b = 0; res_data_b = '0; out_ready_b = 0;
    tick;
    tick;
    rst = 1'b0;
    exp_err = 1'b0;
  endtask

  // One block through DUT A with eng_ready=1, out_ready=1 and a fixed engine latency.
  task automatic run_block(input logic [CW-1:0] coeff, input logic [7:0] qp, input int lat,
                           input string tag);
    logic [2:0]     zm = zmask_of(coeff);
    int             nz[$];
    int             n, exp_cyc, issued, cyc;
    logic [RCW-1:0] exp_slot[3];
    int             due_q[$];
    int             cmp_q[$];
    logic [RCW-1:0] dat_q[$];
    logic [RCW-1:0] d;
    bit             done = 0;
    for (int k = 0; k < 3; k++) begin
      exp_slot[k] = '0;
      if (!zm[k]) nz.push_back(k);
    end
    n = nz.size();
    exp_cyc = (n == 0) ? 1 : n + lat + 1;
    issued = 0;
    in_valid = 1; in_coeff = coeff; in_qp = qp; eng_ready = 1; out_ready = 1; res_valid = 0;
    vec++;
    if (in_ready !== 1'b1) begin
      errs++; $display("FAIL %s accept_ready: got %b want 1", tag, in_ready);
    end
    tick;
    in_valid = 0; in_coeff = rand_coeff(3'b000); in_qp = 8'($urandom);
    for (cyc = 1; cyc < 200 && !done; cyc++) begin
      res_valid = 0;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        void'(due_q.pop_front());
        res_valid = 1; res_comp = 2'(cmp_q.pop_front()); res_data = dat_q.pop_front();
      end
      if (eng_valid) begin
        vec++;
        if (issued >= n) begin
          errs++; $display("FAIL %s extra_issue: got comp %0d at cycle %0d want none", tag,
                           eng_comp, cyc);
        end else begin
          if (cyc != issued + 1 || eng_comp !== 2'(nz[issued]) || eng_qp !== qp) begin
            errs++;
            $display("FAIL %s issue: got comp %0d qp %0d cycle %0d want comp %0d qp %0d cycle %0d",
                     tag, eng_comp, eng_qp, cyc, nz[issued], qp, issued + 1);
          end
          vec++;
          if (eng_coeff !== slot_coeff(coeff, nz[issued])) begin
            errs++; $display("FAIL %s eng_coeff: got %h want %h", tag, eng_coeff,
                             slot_coeff(coeff, nz[issued]));
          end
          d = rand_res();
          exp_slot[nz[issued]] = d;
          due_q.push_back(cyc + lat); cmp_q.push_back(nz[issued]); dat_q.push_back(d);
          issued++;
        end
      end
      if (out_valid) begin
        done = 1;
        vec++;
        if (cyc != exp_cyc) begin
          errs++; $display("FAIL %s out_cycle: got %0d want %0d", tag, cyc, exp_cyc);
        end
        vec++;
        if (out_res !== {exp_slot[2], exp_slot[1], exp_slot[0]}) begin
          errs++; $display("FAIL %s out_res: got %h want %h", tag, out_res,
                           {exp_slot[2], exp_slot[1], exp_slot[0]});
        end
        vec++;
        if (out_zmask !== zm || err !== exp_err) begin
          errs++; $display("FAIL %s zmask_err: got %b/%b want %b/%b", tag, out_zmask, err, zm,
                           exp_err);
        end
      end
      tick;
    end
    res_valid = 0;
    vec++;
    if (!done || issued != n) begin
      errs++; $display("FAIL %s completion: got done %0d issued %0d want 1 %0d", tag, done,
                       issued, n);
    end
    vec++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errs++; $display("FAIL %s back_idle: got ready %b busy %b want 1 0", tag, in_ready, busy);
    end
  endtask

  task automatic test_reset;
    do_reset;
    vec++;
    if ({in_ready, eng_valid, out_valid, busy, err} !== 5'b10000) begin
      errs++; $display("FAIL reset_ctrl: got %b want 10000",
                       {in_ready, eng_valid, out_valid, busy, err});
    end
    vec++;
    if (out_res !== '0 || out_zmask !== 3'b000 || eng_comp !== 2'd0 || eng_qp !== 8'd0 ||
        eng_coeff !== '0) begin
      errs++; $display("FAIL reset_data: got zmask %b comp %0d qp %0d want all zero",
                       out_zmask, eng_comp, eng_qp);
    end
  endtask

  task automatic test_all_nonzero;
    run_block(rand_coeff(3'b000), 8'd20, 4, "all_nonzero");
  endtask

  task automatic test_zero_comp;
    run_block(rand_coeff(3'b010), 8'($urandom), 3, "zero_comp1");
  endtask

  task automatic test_all_zero;
    run_block('0, 8'($urandom), 4, "all_zero");
  endtask

  task automatic test_random;
    for (int i = 0; i < 20; i++) begin
      run_block(rand_coeff(3'($urandom_range(0, 7))), 8'($urandom), $urandom_range(1, 6),
                "random");
    end
  endtask

  // Returns in order 2,0,1, then a duplicate in DONE and a stray return in IDLE.
  task automatic test_ooo;
    logic [CW-1:0]  coeff = rand_coeff(3'b000);
    logic [RCW-1:0] d[3];
    for (int k = 0; k < 3; k++) d[k] = rand_res();
    in_valid = 1; in_coeff = coeff; in_qp = 8'($urandom); eng_ready = 1; out_ready = 0;
    tick;
    in_valid = 0;
    for (int cyc = 1; cyc <= 13; cyc++) begin
      res_valid = 0;
      case (cyc)
        5:  begin res_valid = 1; res_comp = 2'd2; res_data = d[2]; end
        6:  begin res_valid = 1; res_comp = 2'd0; res_data = d[0]; end
        7:  begin res_valid = 1; res_comp = 2'd1; res_data = d[1]; end
        9:  begin res_valid = 1; res_comp = 2'd0; res_data = rand_res(); end
        12: begin res_valid = 1; res_comp = 2'd1; res_data = rand_res(); end
        default: ;
      endcase
      if (cyc <= 4) begin
        vec++;
        if (eng_valid !== (cyc <= 3) || (cyc <= 3 && eng_comp !== 2'(cyc - 1))) begin
          errs++; $display("FAIL ooo_issue: cycle %0d got valid %b comp %0d", cyc, eng_valid,
                           eng_comp);
        end
      end
      if (cyc == 8 || cyc == 9) begin
        vec++;
        if (out_valid !== 1'b1 || err !== 1'b0) begin
          errs++; $display("FAIL ooo_done: cycle %0d got out_valid %b err %b want 1 0", cyc,
                           out_valid, err);
        end
      end
      if (cyc == 10) begin
        vec++;
        if (err !== 1'b1) begin
          errs++; $display("FAIL ooo_dup_err: got %b want 1", err);
        end
        vec++;
        if (out_valid !== 1'b1 || out_res !== {d[2], d[1], d[0]}) begin
          errs++; $display("FAIL ooo_out_res: got %h want %h", out_res, {d[2], d[1], d[0]});
        end
        out_ready = 1;
      end
      if (cyc == 11 || cyc == 13) begin
        vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || err !== 1'b1) begin
          errs++; $display("FAIL ooo_idle: cycle %0d got ready %b valid %b err %b want 1 0 1",
                           cyc, in_ready, out_valid, err);
        end
      end
      tick;
    end
    res_valid = 0;
    exp_err = 1'b1;
    run_block(rand_coeff(3'($urandom_range(0, 6))), 8'($urandom), 2, "after_err");
  endtask

  task automatic test_reset_mid;
    in_valid = 1; in_coeff = rand_coeff(3'b000); in_qp = 8'($urandom); eng_ready = 1;
    out_ready = 1;
    tick;
    in_valid = 0;
    for (int i = 1; i < 5; i++) tick;
    vec++;
    if (busy !== 1'b1 || eng_valid !== 1'b0 || out_valid !== 1'b0) begin
      errs++; $display("FAIL rst_mid_wait: got busy %b eng_valid %b out_valid %b want 1 0 0",
                       busy, eng_valid, out_valid);
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    exp_err = 1'b0;
    vec++;
    if ({out_valid, eng_valid, busy, in_ready, err} !== 5'b00010) begin
      errs++; $display("FAIL rst_mid_state: got %b want 00010",
                       {out_valid, eng_valid, busy, in_ready, err});
    end
    run_block(rand_coeff(3'b000), 8'($urandom), 3, "after_rst");
  endtask

  // DUT B has MAX_OUTST=1: at most one component in flight, engine and downstream stall.
  task automatic test_backpressure;
    logic [CW-1:0]  coeff = rand_coeff(3'b000);
    logic [7:0]     qp = 8'($urandom);
    logic [RCW-1:0] exp_slot[3];
    logic [EW-1:0]  held;
    logic [RCW-1:0] d;
    int             due_q[$];
    int             cmp_q[$];
    logic [RCW-1:0] dat_q[$];
    int             outst = 0, issued = 0, stall = 0, ohold = 0;
    bit             done = 0, ret;
    in_valid_b = 1; in_coeff_b = coeff; in_qp_b = qp; eng_ready_b = 1; out_ready_b = 1;
    vec++;
    if (in_ready_b !== 1'b1) begin
      errs++; $display("FAIL bp_accept: got %b want 1", in_ready_b);
    end
    tick;
    in_valid_b = 0; in_coeff_b = '0;
    for (int cyc = 1; cyc < 80 && !done; cyc++) begin
      res_valid_b = 0;
      ret = 0;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        void'(due_q.pop_front());
        res_valid_b = 1; res_comp_b = 2'(cmp_q.pop_front()); res_data_b = dat_q.pop_front();
        ret = 1;
      end
      eng_ready_b = 1;
      if (eng_valid_b) begin
        vec++;
        if (outst >= 1 || issued >= 3) begin
          errs++; $display("FAIL bp_over_issue: cycle %0d got outstanding %0d issued %0d", cyc,
                           outst, issued);
        end else begin
          vec++;
          if (eng_comp_b !== 2'(issued) || eng_coeff_b !== slot_coeff(coeff, issued) ||
              eng_qp_b !== qp) begin
            errs++; $display("FAIL bp_issue: got comp %0d qp %0d want comp %0d qp %0d",
                             eng_comp_b, eng_qp_b, issued, qp);
          end
          if (issued == 1 && stall < 5) begin
            eng_ready_b = 0;
            if (stall > 0) begin
              vec++;
              if (eng_coeff_b !== held) begin
                errs++; $display("FAIL bp_coeff_stable: got %h want %h", eng_coeff_b, held);
              end
            end
            held = eng_coeff_b;
            stall++;
          end else begin
            d = rand_res();
            exp_slot[issued] = d;
            due_q.push_back(cyc + 2); cmp_q.push_back(issued); dat_q.push_back(d);
            issued++;
            outst++;
          end
        end
      end
      if (ret) outst--;
      if (out_valid_b) begin
        vec++;
        if (out_res_b !== {exp_slot[2], exp_slot[1], exp_slot[0]} || out_zmask_b !== 3'b000) begin
          errs++; $display("FAIL bp_out: got %h zmask %b", out_res_b, out_zmask_b);
        end
        if (ohold < 3) begin
          out_ready_b = 0;
          ohold++;
        end else begin
          out_ready_b = 1;
          done = 1;
        end
      end
      vec++;
      if (in_ready_b !== 1'b0) begin
        errs++; $display("FAIL bp_in_ready: cycle %0d got %b want 0", cyc, in_ready_b);
      end
      tick;
    end
    res_valid_b = 0;
    vec++;
    if (!done || stall != 5 || issued != 3) begin
      errs++; $display("FAIL bp_completion: got done %0d stall %0d issued %0d want 1 5 3", done,
                       stall, issued);
    end
    vec++;
    if (in_ready_b !== 1'b1 || out_valid_b !== 1'b0 || err_b !== 1'b0) begin
      errs++; $display("FAIL bp_idle: got ready %b valid %b err %b want 1 0 0", in_ready_b,
                       out_valid_b, err_b);
    end
  endtask

  initial begin
    test_reset;
    test_all_nonzero;
    test_zero_comp;
    test_all_zero;
    test_random;
    test_ooo;
    test_reset_mid;
    test_backpressure;
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
